// File: rtl/core_bus_pkg.sv
// Shared types for the core bus: which master issued an outstanding transaction.
package core_bus_pkg;

   typedef enum logic {
      OWN_INSTR = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

endpackage

// File: rtl/core_owner_fifo.sv
// Owner FIFO: remembers which master issued each outstanding transaction, in order.
module core_owner_fifo
   import core_bus_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  owner_e        wdata,
   output owner_e        rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   owner_e        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= OWN_INSTR;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= next_ptr(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
         if (do_push && !do_pop) count_q <= count_q + CW'(1);
         else if (!do_push && do_pop) count_q <= count_q - CW'(1);
      end
   end

endmodule

// File: rtl/core_mem_arbiter.sv
// Merges the core's instruction and data masters onto one shared memory port,
// data-priority with instruction anti-starvation, responses steered by an owner FIFO.
module core_mem_arbiter
   import core_bus_pkg::*;
#(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned OUTSTANDING  = 2,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [DW/8-1:0] d_be,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            s_req,
   output logic            s_we,
   output logic [DW/8-1:0] s_be,
   output logic [AW-1:0]   s_addr,
   output logic [DW-1:0]   s_wdata,
   input  logic            s_gnt,
   input  logic            s_rvalid,
   input  logic [DW-1:0]   s_rdata,
   output logic            proto_err
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned CW = $clog2(OUTSTANDING + 1);

   owner_e        sel, sel_q, head;
   logic          lock_q;
   logic [SW-1:0] starve_q;
   logic          starve_max, accept, pop;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   assign starve_max = (starve_q == SW'(STARVE_LIMIT));

   always_comb begin
      sel = OWN_INSTR;
      if (lock_q) sel = sel_q;
      else if (d_req && !(i_req && starve_max)) sel = OWN_DATA;
   end

   always_comb begin
      s_req   = ~rst & (i_req | d_req) & ~fifo_full;
      s_we    = 1'b0;
      s_be    = '1;
      s_addr  = i_addr;
      s_wdata = '0;
      if (sel == OWN_DATA) begin
         s_we    = d_we;
         s_be    = d_be;
         s_addr  = d_addr;
         s_wdata = d_wdata;
      end
   end

   assign accept = s_req & s_gnt;
   assign i_gnt  = accept & (sel == OWN_INSTR);
   assign d_gnt  = accept & (sel == OWN_DATA);

   // Responses with nothing outstanding are dropped and never touch the FIFO.
   assign pop      = ~rst & s_rvalid & ~fifo_empty;
   assign i_rvalid = pop & (head == OWN_INSTR);
   assign d_rvalid = pop & (head == OWN_DATA);
   assign i_rdata  = s_rdata;
   assign d_rdata  = s_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q    <= 1'b0;
         sel_q     <= OWN_INSTR;
         starve_q  <= '0;
         proto_err <= 1'b0;
      end else begin
         lock_q <= s_req & ~s_gnt;
         sel_q  <= sel;
         if (accept) begin
            if (sel == OWN_INSTR) starve_q <= '0;
            else if (i_req && !starve_max) starve_q <= starve_q + SW'(1);
         end
         if (s_rvalid && fifo_count == '0) proto_err <= 1'b1;
      end
   end

   core_owner_fifo #(
      .DEPTH(OUTSTANDING)
   ) u_owner_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .wdata (sel),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter with an owner/rdata scoreboard.
module tb_core_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we, s_gnt, s_rvalid;
   logic [31:0] i_addr, d_addr, d_wdata, s_rdata;
   logic [3:0]  d_be;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, s_req, s_we, proto_err;
   logic [31:0] i_rdata, d_rdata, s_addr, s_wdata;
   logic [3:0]  s_be;

   typedef struct packed {
      logic        own;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   core_mem_arbiter #(
      .AW(32), .DW(32), .OUTSTANDING(2), .STARVE_LIMIT(3)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
      .proto_err(proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pops the oldest expected response and checks its routing.
   task automatic resp_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_sb_underflow observed=response expected=none", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_irv"}, {31'd0, i_rvalid}, {31'd0, ~e.own});
         chk({tag, "_drv"}, {31'd0, d_rvalid}, {31'd0, e.own});
         if (e.own) chk({tag, "_drd"}, d_rdata, e.data);
         else chk({tag, "_ird"}, i_rdata, e.data);
      end
   endtask

   task automatic idle_inputs();
      i_req = 0; d_req = 0; d_we = 0; s_gnt = 0; s_rvalid = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; s_rdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      rst = 1;
      // Reset: outputs forced low even with requests and responses present
      i_req = 1; d_req = 1; s_gnt = 1; s_rvalid = 1;
      #4;
      chk("rst_sreq", {31'd0, s_req}, 0);
      chk("rst_ignt", {31'd0, i_gnt}, 0);
      chk("rst_dgnt", {31'd0, d_gnt}, 0);
      chk("rst_rv", {30'd0, i_rvalid, d_rvalid}, 0);
      chk("rst_perr", {31'd0, proto_err}, 0);
      tick(); idle_inputs(); tick(); rst = 0; tick();

      // 1: single instruction read
      i_req = 1; i_addr = 32'h1000_0000; s_gnt = 1;
      #4;
      chk("t1_sreq", {31'd0, s_req}, 1);
      chk("t1_ignt", {31'd0, i_gnt}, 1);
      chk("t1_dgnt", {31'd0, d_gnt}, 0);
      chk("t1_addr", s_addr, 32'h1000_0000);
      chk("t1_we", {31'd0, s_we}, 0);
      chk("t1_be", {28'd0, s_be}, 32'hF);
      chk("t1_wdata", s_wdata, 0);
      sb.push_back('{own: 1'b0, data: 32'h0000_0013});
      tick(); i_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h0000_0013;
      #4; resp_check("t1");
      tick(); s_rvalid = 0;

      // 2: contention, starvation override on the 4th accept
      i_req = 1; i_addr = 32'h1000_0020; d_req = 1; d_we = 1; d_be = 4'hF;
      d_wdata = 32'hAAAA_5555; s_gnt = 1;
      for (int k = 0; k < 4; k++) begin
         d_addr = 32'h2000 + 32'(k) * 4;
         s_rvalid = (k > 0);
         s_rdata = 32'h100 + 32'(k) - 1;
         #4;
         if (k > 0) resp_check("t2");
         chk("t2_dgnt", {31'd0, d_gnt}, (k < 3) ? 1 : 0);
         chk("t2_ignt", {31'd0, i_gnt}, (k < 3) ? 0 : 1);
         chk("t2_addr", s_addr, (k < 3) ? 32'h2000 + 32'(k) * 4 : 32'h1000_0020);
         sb.push_back('{own: (k < 3), data: 32'h100 + 32'(k)});
         tick();
      end
      i_req = 0; d_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h103;
      #4; resp_check("t2");
      tick(); s_rvalid = 0; d_we = 0;

      // 3: data held while slave stalls, instr arrives later
      d_req = 1; d_addr = 32'h3000;
      #4;
      chk("t3_addr0", s_addr, 32'h3000);
      chk("t3_dgnt0", {31'd0, d_gnt}, 0);
      tick(); i_req = 1; i_addr = 32'h1000_0040;
      #4;
      chk("t3_addr1", s_addr, 32'h3000);
      chk("t3_ignt1", {31'd0, i_gnt}, 0);
      tick();
      #4; chk("t3_addr2", s_addr, 32'h3000);
      tick(); s_gnt = 1;
      #4;
      chk("t3_dgnt", {31'd0, d_gnt}, 1);
      sb.push_back('{own: 1'b1, data: 32'h3333});
      tick(); d_req = 0; s_rvalid = 1; s_rdata = 32'h3333;
      #4;
      resp_check("t3");
      chk("t3_ignt", {31'd0, i_gnt}, 1);
      chk("t3_iaddr", s_addr, 32'h1000_0040);
      sb.push_back('{own: 1'b0, data: 32'h4444});
      tick(); i_req = 0; s_gnt = 0; s_rdata = 32'h4444;
      #4; resp_check("t3");
      tick(); s_rvalid = 0;

      // Lock: stalled instr request is not displaced by a later data request
      i_req = 1; i_addr = 32'h1000_0080;
      #4; chk("lk_addr0", s_addr, 32'h1000_0080);
      tick(); d_req = 1; d_we = 1; d_addr = 32'h5000; d_wdata = 32'h1234;
      #4;
      chk("lk_addr1", s_addr, 32'h1000_0080);
      chk("lk_we1", {31'd0, s_we}, 0);
      tick(); s_gnt = 1;
      #4;
      chk("lk_ignt", {31'd0, i_gnt}, 1);
      chk("lk_dgnt", {31'd0, d_gnt}, 0);
      sb.push_back('{own: 1'b0, data: 32'h55});
      tick(); i_req = 0; s_rvalid = 1; s_rdata = 32'h55;
      #4;
      resp_check("lk");
      chk("lk_dgnt2", {31'd0, d_gnt}, 1);
      chk("lk_wdata", s_wdata, 32'h1234);
      sb.push_back('{own: 1'b1, data: 32'h66});
      tick(); d_req = 0; d_we = 0; s_gnt = 0; s_rdata = 32'h66;
      #4; resp_check("lk");
      tick(); s_rvalid = 0;

      // 4: FIFO full blocks requests, even on a same-cycle pop
      i_req = 1; i_addr = 32'h1000_0100; s_gnt = 1;
      #4; chk("t4_ignt0", {31'd0, i_gnt}, 1);
      sb.push_back('{own: 1'b0, data: 32'h71});
      tick();
      #4; chk("t4_ignt1", {31'd0, i_gnt}, 1);
      sb.push_back('{own: 1'b0, data: 32'h72});
      tick();
      #4;
      chk("t4_full_sreq", {31'd0, s_req}, 0);
      chk("t4_full_ignt", {31'd0, i_gnt}, 0);
      tick(); s_rvalid = 1; s_rdata = 32'h71;
      #4;
      chk("t4_pop_sreq", {31'd0, s_req}, 0);
      resp_check("t4");
      tick(); s_rvalid = 0;
      #4;
      chk("t4_resume_sreq", {31'd0, s_req}, 1);
      chk("t4_resume_ignt", {31'd0, i_gnt}, 1);
      sb.push_back('{own: 1'b0, data: 32'h73});
      tick(); i_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h72;
      #4; resp_check("t4");
      tick(); s_rdata = 32'h73;
      #4; resp_check("t4");
      chk("t4_perr", {31'd0, proto_err}, 0);
      tick(); s_rvalid = 0;

      // 5: response with nothing outstanding
      s_rvalid = 1; s_rdata = 32'hDEAD;
      #4;
      chk("t5_rv", {30'd0, i_rvalid, d_rvalid}, 0);
      tick(); s_rvalid = 0;
      #4; chk("t5_perr_set", {31'd0, proto_err}, 1);
      tick();
      #4; chk("t5_perr_held", {31'd0, proto_err}, 1);
      tick(); rst = 1;
      #4; chk("t5_perr_clr", {31'd0, proto_err}, 0);
      tick(); rst = 0; tick();

      // 6: reset with two transactions outstanding
      d_req = 1; d_addr = 32'h6000; s_gnt = 1;
      #4; chk("t6_dgnt0", {31'd0, d_gnt}, 1);
      tick();
      #4; chk("t6_dgnt1", {31'd0, d_gnt}, 1);
      tick();
      #4; chk("t6_full", {31'd0, s_req}, 0);
      tick(); rst = 1; i_req = 1; s_rvalid = 1; s_rdata = 32'h9999;
      #4;
      chk("t6_rst_sreq", {31'd0, s_req}, 0);
      chk("t6_rst_gnt", {30'd0, i_gnt, d_gnt}, 0);
      chk("t6_rst_rv", {30'd0, i_rvalid, d_rvalid}, 0);
      chk("t6_rst_perr", {31'd0, proto_err}, 0);
      tick(); rst = 0; idle_inputs(); tick();
      d_req = 1; d_addr = 32'h6004; s_gnt = 1;
      #4;
      chk("t6_sreq", {31'd0, s_req}, 1);
      chk("t6_dgnt", {31'd0, d_gnt}, 1);
      chk("t6_addr", s_addr, 32'h6004);
      sb.push_back('{own: 1'b1, data: 32'h6666});
      tick(); d_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h6666;
      #4; resp_check("t6");
      tick(); s_rvalid = 0;
      #4; chk("t6_perr", {31'd0, proto_err}, 0);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
